// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: access size codes and the access-unit FSM state encoding.
package mips_mem_pkg;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;
endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane placement: store byte enables / replicated write data, and load byte/half select
// with sign or zero extension. Zero latency, no flow control.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      MEM_SIZE_BYTE: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_SIZE_HALF: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  always_comb begin
    ld_data = ld_rdata;
    case (ld_size)
      MEM_SIZE_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      MEM_SIZE_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store bus master: min 3-cycle occupancy, stalls the pipeline until bus_ack or timeout.
// ADDR_ERR_EXC_EN enables misalignment exceptions; otherwise misaligned accesses are aligned down.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        MemReadInput,
  input  logic        MemWriteInput,
  input  logic [1:0]  MemSizeInput,
  input  logic        MemSignedInput,
  input  logic [31:0] AddrInput,
  input  logic [31:0] StoreDataInput,
  output logic        MemStallOutput,
  output logic [31:0] MemReadDataOutput,
  output logic        BusErrOutput,
  output logic        AddrErrLoadOutput,
  output logic        AddrErrStoreOutput,
  output logic [31:0] BadVAddrOutput,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUS_TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic        kill_q, kill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, signed_q, signed_d, buserr_q, buserr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d, lo_q, lo_d;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_ld;
  logic        is_idle, addr_err, access;

  assign is_idle = (state_q == ST_IDLE);

`ifdef ADDR_ERR_EXC_EN
  logic misaligned;
  assign misaligned = ((MemSizeInput == MEM_SIZE_HALF) & AddrInput[0]) |
                      (MemSizeInput[1] & (AddrInput[1:0] != 2'b00));
  assign addr_err           = misaligned & (MemReadInput | MemWriteInput);
  assign AddrErrLoadOutput  = is_idle & MemReadInput & misaligned;
  assign AddrErrStoreOutput = is_idle & MemWriteInput & misaligned;
  assign BadVAddrOutput     = (AddrErrLoadOutput | AddrErrStoreOutput) ? AddrInput : 32'h0;
`else
  assign addr_err           = 1'b0;
  assign AddrErrLoadOutput  = 1'b0;
  assign AddrErrStoreOutput = 1'b0;
  assign BadVAddrOutput     = 32'h0;
`endif

  assign access         = (MemReadInput | MemWriteInput) & ~clr & ~addr_err;
  assign MemStallOutput = (is_idle & access) | (state_q == ST_BUSY);

  // Store side sees the live request; load side sees the latched request.
  mem_lane_align u_lane (
    .st_size    (MemSizeInput),
    .st_addr_lo (AddrInput[1:0]),
    .st_data    (StoreDataInput),
    .st_be      (lane_be),
    .st_wdata   (lane_wdata),
    .ld_size    (size_q),
    .ld_signed  (signed_q),
    .ld_addr_lo (lo_q),
    .ld_rdata   (bus_rdata),
    .ld_data    (lane_ld)
  );

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    lo_d     = lo_q;
    rdata_d  = rdata_q;
    buserr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          state_d  = ST_BUSY;
          req_d    = 1'b1;
          we_d     = MemWriteInput;
          addr_d   = {AddrInput[31:2], 2'b00};
          be_d     = lane_be;
          wdata_d  = lane_wdata;
          size_d   = MemSizeInput;
          signed_d = MemSignedInput;
          lo_d     = AddrInput[1:0];
          kill_d   = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_BUSY: begin
        if (clr) kill_d = 1'b1;
        if (bus_ack) begin
          req_d  = 1'b0;
          kill_d = 1'b0;
          cnt_d  = '0;
          if (kill_q | clr) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            if (!we_q) rdata_d = lane_ld;
          end
        end else if ((BUS_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          req_d  = 1'b0;
          kill_d = 1'b0;
          cnt_d  = '0;
          // A flushed instruction must not raise an exception of its own.
          if (kill_q | clr) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_DONE;
            buserr_d = 1'b1;
            rdata_d  = 32'h0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      kill_q   <= 1'b0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      lo_q     <= 2'b00;
      rdata_q  <= 32'h0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      lo_q     <= lo_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

  assign bus_req           = req_q;
  assign bus_we            = we_q;
  assign bus_addr          = addr_q;
  assign bus_be            = be_q;
  assign bus_wdata         = wdata_q;
  assign MemReadDataOutput = rdata_q;
  assign BusErrOutput      = buserr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected bus/pipeline results queued per access, popped on completion.
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic        MemReadInput = 1'b0, MemWriteInput = 1'b0, MemSignedInput = 1'b0;
  logic [1:0]  MemSizeInput = 2'b00;
  logic [31:0] AddrInput = 32'h0, StoreDataInput = 32'h0, bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic        MemStallOutput, BusErrOutput, AddrErrLoadOutput, AddrErrStoreOutput;
  logic        bus_req, bus_we;
  logic [31:0] MemReadDataOutput, BadVAddrOutput, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  mem_access_unit #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .MemReadInput(MemReadInput), .MemWriteInput(MemWriteInput),
    .MemSizeInput(MemSizeInput), .MemSignedInput(MemSignedInput),
    .AddrInput(AddrInput), .StoreDataInput(StoreDataInput),
    .MemStallOutput(MemStallOutput), .MemReadDataOutput(MemReadDataOutput),
    .BusErrOutput(BusErrOutput), .AddrErrLoadOutput(AddrErrLoadOutput),
    .AddrErrStoreOutput(AddrErrStoreOutput), .BadVAddrOutput(BadVAddrOutput),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;

  int          obs_stalls, obs_req_n;
  logic        obs_we, obs_unstable, obs_err, obs_aerr_ld, obs_aerr_st;
  logic [31:0] obs_addr, obs_wdata, obs_data, obs_badv;
  logic [3:0]  obs_be;

  // Reference lane model: byte/half extraction by shifting the bus word.
  function automatic logic [31:0] model_load(logic [1:0] sz, logic sg, logic [1:0] lo, logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * lo);
    if (sz == 2'b00) return (sg && sh[7]) ? (sh | 32'hFFFFFF00) : (sh & 32'h000000FF);
    sh = rd >> (16 * lo[1]);
    if (sz == 2'b01) return (sg && sh[15]) ? (sh | 32'hFFFF0000) : (sh & 32'h0000FFFF);
    return rd;
  endfunction

  // Presents one MEM-stage instruction until the pipeline is released; ack_at/clr_at count BUSY cycles (0 = never).
  task automatic run_access(input logic r, input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                            input int ack_at, input int clr_at);
    int  req_n;
    bit  gone, killed;
    req_n = 0; gone = 0; killed = 0;
    obs_stalls = 0; obs_unstable = 1'b0; obs_err = 1'b0;
    for (int cyc = 0; cyc < 40 && !gone; cyc++) begin
      @(negedge clk);
      if (bus_req) begin
        req_n++;
        if (req_n == 1) begin
          obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata; obs_we = bus_we;
        end else if ({bus_addr, bus_be, bus_wdata, bus_we} != {obs_addr, obs_be, obs_wdata, obs_we}) begin
          obs_unstable = 1'b1;
        end
      end
      MemReadInput = r & !killed; MemWriteInput = w & !killed;
      MemSizeInput = sz; MemSignedInput = sg; AddrInput = addr; StoreDataInput = sdata;
      bus_rdata = rdata;
      bus_ack = bus_req && (req_n == ack_at);
      clr = bus_req && (req_n == clr_at);
      #1;
      if (cyc == 0) begin
        obs_aerr_ld = AddrErrLoadOutput; obs_aerr_st = AddrErrStoreOutput; obs_badv = BadVAddrOutput;
      end
      if (BusErrOutput) obs_err = 1'b1;
      if (MemStallOutput) obs_stalls++;
      else begin gone = 1; obs_data = MemReadDataOutput; end
      if (clr) killed = 1;
    end
    obs_req_n = req_n;
    checks++;
    if (!gone) begin failures++; $display("FAIL access_bound: stall still high after 40 cycles at addr %h", addr); end
    @(negedge clk);
    MemReadInput = 1'b0; MemWriteInput = 1'b0; clr = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus_req); end
    checks++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== 69'h0) begin failures++; $display("FAIL rst_bus got=%h exp=0", {bus_we, bus_be, bus_addr, bus_wdata}); end
    checks++; if (MemReadDataOutput !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", MemReadDataOutput); end
    checks++; if ({MemStallOutput, BusErrOutput} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {MemStallOutput, BusErrOutput}); end
    @(negedge clk); rst = 1'b1;
    // Stray ack while idle must do nothing.
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h5555AAAA;
    @(negedge clk); bus_ack = 1'b0; #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL idle_ack_req got=%b exp=0", bus_req); end
    checks++; if (MemReadDataOutput !== 32'h0) begin failures++; $display("FAIL idle_ack_rdata got=%h exp=0", MemReadDataOutput); end
  endtask

  task automatic test_word_load();
    sb.push_back('{we: 1'b0, addr: 32'h100, be: 4'hF, wdata: 32'h0, data: 32'hDEADBEEF, stalls: 2});
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0);
    e = sb.pop_front();
    checks++; if (obs_addr !== e.addr) begin failures++; $display("FAIL wl_addr got=%h exp=%h", obs_addr, e.addr); end
    checks++; if ({obs_we, obs_be} !== {e.we, e.be}) begin failures++; $display("FAIL wl_we_be got=%b exp=%b", {obs_we, obs_be}, {e.we, e.be}); end
    checks++; if (obs_stalls !== e.stalls) begin failures++; $display("FAIL wl_stalls got=%0d exp=%0d", obs_stalls, e.stalls); end
    checks++; if (obs_data !== e.data) begin failures++; $display("FAIL wl_data got=%h exp=%h", obs_data, e.data); end
    #1;
    checks++; if ({bus_req, MemStallOutput} !== 2'b00) begin failures++; $display("FAIL wl_no_reissue got=%b exp=00", {bus_req, MemStallOutput}); end
  endtask

  task automatic test_byte_load();
    for (int s = 1; s >= 0; s--) begin
      sb.push_back('{we: 1'b0, addr: 32'h100, be: 4'h8, wdata: 32'h0,
                     data: (s == 1) ? 32'hFFFFFF80 : 32'h00000080, stalls: 2});
      run_access(1'b1, 1'b0, 2'b00, s[0], 32'h103, 32'h0, 32'h80000000, 1, 0);
      e = sb.pop_front();
      checks++; if (obs_data !== e.data) begin failures++; $display("FAIL bl_data signed=%0d got=%h exp=%h", s, obs_data, e.data); end
    end
  endtask

  task automatic test_half_store();
    sb.push_back('{we: 1'b1, addr: 32'h200, be: 4'b1100, wdata: 32'h12341234, data: 32'h00000080, stalls: 5});
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234, 32'hFFFFFFFF, 4, 0);
    e = sb.pop_front();
    checks++; if ({obs_we, obs_addr} !== {e.we, e.addr}) begin failures++; $display("FAIL hs_addr got=%h exp=%h", {obs_we, obs_addr}, {e.we, e.addr}); end
    checks++; if (obs_be !== e.be) begin failures++; $display("FAIL hs_be got=%b exp=%b", obs_be, e.be); end
    checks++; if (obs_wdata !== e.wdata) begin failures++; $display("FAIL hs_wdata got=%h exp=%h", obs_wdata, e.wdata); end
    checks++; if (obs_stalls !== e.stalls) begin failures++; $display("FAIL hs_stalls got=%0d exp=%0d", obs_stalls, e.stalls); end
    checks++; if (obs_unstable !== 1'b0) begin failures++; $display("FAIL hs_bus_stable got=%b exp=0", obs_unstable); end
    checks++; if ({obs_data, obs_err} !== {e.data, 1'b0}) begin failures++; $display("FAIL hs_rdata_kept got=%h exp=%h", {obs_data, obs_err}, {e.data, 1'b0}); end
  endtask

  task automatic test_clr_busy();
    sb.push_back('{we: 1'b0, addr: 32'h300, be: 4'hF, wdata: 32'h0, data: 32'h00000080, stalls: 4});
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 3, 2);
    e = sb.pop_front();
    checks++; if (obs_req_n !== 3) begin failures++; $display("FAIL clr_req_cycles got=%0d exp=3", obs_req_n); end
    checks++; if (obs_stalls !== e.stalls) begin failures++; $display("FAIL clr_stalls got=%0d exp=%0d", obs_stalls, e.stalls); end
    checks++; if (obs_data !== e.data) begin failures++; $display("FAIL clr_rdata got=%h exp=%h", obs_data, e.data); end
  endtask

  task automatic test_timeout();
    sb.push_back('{we: 1'b0, addr: 32'h400, be: 4'hF, wdata: 32'h0, data: 32'h0, stalls: 5});
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h13579BDF, 0, 0);
    e = sb.pop_front();
    checks++; if (obs_req_n !== 4) begin failures++; $display("FAIL to_busy_cycles got=%0d exp=4", obs_req_n); end
    checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL to_buserr got=%b exp=1", obs_err); end
    checks++; if (obs_data !== e.data) begin failures++; $display("FAIL to_rdata got=%h exp=%h", obs_data, e.data); end
    checks++; if (obs_stalls !== e.stalls) begin failures++; $display("FAIL to_stalls got=%0d exp=%0d", obs_stalls, e.stalls); end
    #1;
    checks++; if ({BusErrOutput, bus_req} !== 2'b00) begin failures++; $display("FAIL to_pulse_end got=%b exp=00", {BusErrOutput, bus_req}); end
  endtask

  task automatic test_misaligned();
`ifdef ADDR_ERR_EXC_EN
    sb.push_back('{we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0, data: 32'h0, stalls: 0});
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h11223344, 1, 0);
    e = sb.pop_front();
    checks++; if ({obs_aerr_ld, obs_aerr_st} !== 2'b10) begin failures++; $display("FAIL ma_aerr got=%b exp=10", {obs_aerr_ld, obs_aerr_st}); end
    checks++; if (obs_badv !== 32'h102) begin failures++; $display("FAIL ma_badv got=%h exp=00000102", obs_badv); end
    checks++; if (obs_req_n !== 0) begin failures++; $display("FAIL ma_req got=%0d exp=0", obs_req_n); end
    checks++; if (obs_stalls !== e.stalls) begin failures++; $display("FAIL ma_stalls got=%0d exp=%0d", obs_stalls, e.stalls); end
`else
    sb.push_back('{we: 1'b0, addr: 32'h100, be: 4'hF, wdata: 32'h0, data: 32'h11223344, stalls: 2});
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h11223344, 1, 0);
    e = sb.pop_front();
    checks++; if (obs_addr !== e.addr) begin failures++; $display("FAIL ma_addr got=%h exp=%h", obs_addr, e.addr); end
    checks++; if (obs_be !== e.be) begin failures++; $display("FAIL ma_be got=%b exp=%b", obs_be, e.be); end
    checks++; if (obs_data !== e.data) begin failures++; $display("FAIL ma_data got=%h exp=%h", obs_data, e.data); end
    checks++; if ({obs_aerr_ld, obs_aerr_st, obs_badv} !== 34'h0) begin failures++; $display("FAIL ma_err_tied got=%h exp=0", {obs_aerr_ld, obs_aerr_st, obs_badv}); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0] lo;
    for (int i = 0; i < 4; i++) begin
      lo = i[1:0];
      sb.push_back('{we: 1'b1, addr: 32'h500, be: 4'(1 << i), wdata: 32'hD8D8D8D8, data: 32'h0, stalls: 2});
      run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h500 | 32'(i), 32'hA5B6C7D8, 32'h0, 1, 0);
      e = sb.pop_front();
      checks++; if (obs_be !== e.be) begin failures++; $display("FAIL b2b_be lane=%0d got=%b exp=%b", i, obs_be, e.be); end
      checks++; if (obs_wdata !== e.wdata) begin failures++; $display("FAIL b2b_wdata lane=%0d got=%h exp=%h", i, obs_wdata, e.wdata); end
      sb.push_back('{we: 1'b0, addr: 32'h600, be: 4'(1 << i), wdata: 32'h0,
                     data: model_load(2'b00, i[0], lo, 32'h8899AABB), stalls: 2});
      run_access(1'b1, 1'b0, 2'b00, i[0], 32'h600 | 32'(i), 32'h0, 32'h8899AABB, 1, 0);
      e = sb.pop_front();
      checks++; if (obs_data !== e.data) begin failures++; $display("FAIL b2b_load lane=%0d got=%h exp=%h", i, obs_data, e.data); end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_clr_busy();
    test_timeout();
    test_misaligned();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the MIPS32 pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It converts load/store requests into aligned word-bus transactions with byte enables, and stalls the pipeline until the bus acknowledges. It also delivers the size-adjusted, sign/zero-extended load data that MEM/WB captures as its memory-read data.

## Interface
- `BUS_TIMEOUT`, default 255: maximum cycles spent waiting for `bus_ack` before a bus error is forced. 0 disables the timeout.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `clr` in 1: flush of the current MEM-stage instruction.
- `MemReadInput` in 1: the current instruction is a load.
- `MemWriteInput` in 1: the current instruction is a store.
- `MemSizeInput` in 2: access size, 00 byte, 01 half, 10 word (11 treated as word).
- `MemSignedInput` in 1: sign-extend load data (1) or zero-extend (0).
- `AddrInput` in 32: effective byte address.
- `StoreDataInput` in 32: store data, right-justified.
- `MemStallOutput` out 1: holds PC, IF/ID, ID/EX and EX/MEM; forces MEM/WB `writeEN`=0.
- `MemReadDataOutput` out 32: extended load data; valid in the DONE cycle.
- `BusErrOutput` out 1: one-cycle pulse on a bus timeout.
- `AddrErrLoadOutput`, `AddrErrStoreOutput` out 1: misalignment flags (see Configuration).
- `BadVAddrOutput` out 32: faulting address, for CP0.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: bus write enable, registered.
- `bus_addr` out 32: word-aligned bus address, with [1:0]=00; registered.
- `bus_be` out 4: byte enables; registered.
- `bus_wdata` out 32: lane-placed write data; registered.
- `bus_rdata` in 32: bus read data; sampled when `bus_ack`=1.
- `bus_ack` in 1: one-cycle completion from the bus.

## Operation
- FSM states: IDLE, BUSY, DONE.
- `access` = (`MemReadInput` | `MemWriteInput`) & !`clr` & !addr_err.
- IDLE:
  - If `access`: latch bus address, `be`, `wdata`, `we`, size, signedness and addr[1:0], then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `bus_req`=1 and all bus outputs held stable until `bus_ack`.
  - On `bus_ack` go to DONE. For a load, register the extended data into `MemReadDataOutput`.
- DONE:
  - `bus_req`=0. Go to IDLE unconditionally.
  - The still-present instruction is never re-issued.
- `MemStallOutput` = (IDLE & `access`) | BUSY. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Lane rules for stores:
  - Byte: `be` = 1<<addr[1:0]; `wdata` = the byte replicated ×4.
  - Half: `be` = addr[1] ? 1100 : 0011; `wdata` = the half replicated ×2.
  - Word: `be` = 1111; `wdata` = the data unchanged.
- Lane rules for loads:
  - Select the byte by addr[1:0], or the half by addr[1].
  - Extend per `MemSignedInput`.
- `MemReadDataOutput` holds its value until the next load completes; stores do not change it.
- `clr` during BUSY:
  - The bus transaction still completes.
  - A kill flag is set. On `bus_ack` the FSM goes to IDLE instead of DONE, and the read data is discarded.
  - Stall remains asserted until `bus_ack`.
- Timeout:
  - A counter runs in BUSY.
  - When it reaches `BUST_TIMEOUT`-equivalent `BUS_TIMEOUT` with no ack, the FSM goes to DONE, pulses `BusErrOutput`, and sets read data to 0.
  - `bus_req` drops the same edge.
- Reset: state IDLE; all registered outputs 0, including `MemReadDataOutput`; kill flag and counter 0.

## Timing
- Minimum occupancy is 3 cycles:
  - Cycle 0: request seen, stall=1.
  - Cycle 1: `bus_req`=1.
  - `bus_ack` in cycle 1 gives DONE in cycle 2, with data valid and stall=0.
- Each extra wait cycle of `bus_ack` adds one stall cycle.
- `bus_ack` outside BUSY is ignored.
- Error outputs are combinational from the inputs, qualified by IDLE. The exception logic flushes via `clr` in the same cycle.
- Reset asserted mid-transaction aborts immediately. Bus cleanup is the bus's responsibility.

## Configuration
- `ADDR_ERR_EXC_EN` defined:
  - An address error is a half access with addr[0]=1, or a word access with addr[1:0]≠00.
  - On an address error, assert `AddrErrLoadOutput` or `AddrErrStoreOutput` (by access type) and drive `BadVAddrOutput`=`AddrInput`.
  - The access is suppressed, with no stall.
- Undefined:
  - addr_err = 0. Misaligned accesses are aligned down (half ignores addr[0], word ignores addr[1:0]) and proceed.
  - The error outputs and `BadVAddrOutput` are tied to 0.

## Structure
- Shared package `mips_mem_pkg`: `MEM_SIZE_BYTE`/`HALF`/`WORD` constants and the FSM state encoding.
- Sub-module `mem_lane_align`: combinational `be`/`wdata` placement plus load byte/half select and extension; instantiated once.

## Test plan
- Word load, addr 0x100, `bus_rdata`=0xDEADBEEF, ack in first BUSY cycle → stall for 2 cycles, then DONE with `MemReadDataOutput`=0xDEADBEEF.
- Signed byte load at addr 0x103, `bus_rdata`=0x80000000 → 0xFFFFFF80; the unsigned variant gives 0x00000080.
- Half store 0x1234 at addr 0x202, ack delayed by 3 cycles → `bus_addr`=0x200, `be`=1100, `wdata`=0x12341234, 5 stall cycles in total.
- `clr` in the second BUSY cycle of a load → transaction completes, no DONE, `MemReadDataOutput` unchanged.
- No ack with `BUS_TIMEOUT`=4 → `BusErrOutput` pulse after 4 BUSY cycles, read data 0, FSM back to IDLE.
- Word load at 0x102 → with `ADDR_ERR_EXC_EN`: `AddrErrLoadOutput`=1, `BadVAddrOutput`=0x102, no `bus_req`. Without the macro: access at 0x100, `be`=1111.
